mem_stage_sram: RTL and testbench
=================================

Name: mem_stage_sram

Overview:
- Memory stage, sits directly downstream of the execute stage.
- Consumes the execute stage's ALU result (used as address), forwarded Rm value (store data), MEM_R_EN/MEM_W_EN, WB_EN and Dest.
- Performs 32-bit loads and stores on an external 16-bit asynchronous SRAM as two half-word accesses.
- Drives a ready signal; the hazard/freeze logic uses ready low to stall all upstream pipeline registers.

Parameters:
- ADDR_BASE, 1024: byte address mapped to SRAM word 0.
- HALF_CYCLES, 2: clock cycles each half-word access is held on the SRAM pins (minimum 1).
- SRAM_AW, 18: SRAM address width.

Ports:
- clk  in  1  stage clock, rising edge.
- rst  in  1  asynchronous reset, active-low.
- wb_en_in  in  1  write-back enable from execute.
- mem_r_en  in  1  load request.
- mem_w_en  in  1  store request.
- alu_res  in  32  byte address, or non-memory result.
- val_rm  in  32  store data.
- dest_in  in  4  destination register.
- ready  out  1  high = stage may advance; low = freeze pipeline.
- wb_en_out  out  1  combinational pass-through of wb_en_in.
- mem_r_en_out  out  1  combinational pass-through of mem_r_en.
- alu_res_out  out  32  combinational pass-through of alu_res.
- dest_out  out  4  combinational pass-through of dest_in.
- mem_data  out  32  load result.
- SRAM_DQ  inout  16  SRAM data bus.
- SRAM_ADDR  out  SRAM_AW  SRAM half-word address.
- SRAM_WE_N  out  1  SRAM write strobe, active-low.
- SRAM_OE_N  out  1  SRAM output enable, active-low.

Behaviour:
- Request and address:
  - req = mem_r_en | mem_w_en.
  - If both are high, the request is a write.
  - word = (alu_res - ADDR_BASE) >> 2, 32-bit unsigned subtraction, truncated to SRAM_AW-1 bits.
  - SRAM_ADDR = {word, half}, where half=0 is the low 16 bits and half=1 is the high 16 bits.
- FSM states: IDLE, LO, HI, DONE, plus a counter cnt of width clog2(HALF_CYCLES).
- IDLE:
  - ready = ~req.
  - On req: latch address, direction and val_rm; go to LO with cnt=0.
- LO / HI:
  - Drive the corresponding half on the pins for HALF_CYCLES cycles.
  - On the last cycle of each half (cnt==HALF_CYCLES-1): read samples SRAM_DQ into the matching half of the data register; LO moves to HI, HI moves to DONE.
  - Write: SRAM_WE_N=0 and SRAM_DQ driven with the latched half, for every cycle of the half except the last. In the last cycle WE_N=1 with data still driven (hold time).
  - Read: OE_N=0, DQ high-Z.
- DONE:
  - ready=1 for exactly one cycle; mem_data is valid this cycle and holds until the next load completes.
  - Unconditional transition to IDLE. The upstream pipeline advances on this edge, so the same request is never re-issued.
- Occupancy: a memory request holds ready low for 2*HALF_CYCLES+1 cycles (IDLE cycle plus both halves); ready rises in the following cycle (DONE).
- Non-memory instructions: ready stays 1, no SRAM activity.
- Outside writes: SRAM_DQ is high-Z.
- Control and address pass-throughs stay combinational in every state. They are stable while frozen because upstream is held.
- Reset (asserted at any time, including mid-access): FSM=IDLE, cnt=0, mem_data=0, SRAM_WE_N=1, SRAM_OE_N=1, SRAM_ADDR=0, DQ high-Z.
  - While rst is low, ready=1 (IDLE with req forced 0).
  - An interrupted write may leave the SRAM word partially written; this is accepted.
- Address wrap: addresses below ADDR_BASE wrap modulo 2^(SRAM_AW-1) words. No fault is raised.

Optional Feature:
- Macro: MEM_STAGE_READ_BUFFER_EN.
- Defined: a one-entry read buffer holding {valid, word, data}.
  - Filled on every completed load.
  - In IDLE, a load whose word matches a valid entry is a hit:
    - ready=1 in the same cycle;
    - mem_data is combinationally the buffered data;
    - no SRAM access is made.
  - A store to the matching word updates the buffer data at DONE.
  - Reset clears valid.
- Undefined: no buffer; every load takes the full FSM path.

Decomposition:
- Shared package/header (configs):
  - WORD_LEN=32 and SRAM data width 16;
  - FSM state encodings, 2 bits: IDLE=0, LO=1, HI=2, DONE=3.
- Sub-module sram_ctrl owns the FSM, counter, data register and pins.
- mem_stage_sram wraps sram_ctrl, adds the pass-throughs, address computation and, when enabled, the read buffer.

Test Plan:
- Store then load, HALF_CYCLES=2:
  - Store alu_res=1024, val_rm=0xDEADBEEF: ready low 5 cycles; SRAM[0]=0xBEEF and SRAM[1]=0xDEAD.
  - Load at 1024: ready high in the 6th cycle and mem_data=0xDEADBEEF.
- Non-memory op with alu_res=0x1234, wb_en_in=1: ready=1 every cycle, alu_res_out=0x1234, SRAM_WE_N=1, SRAM_OE_N=1.
- Address mapping: load at alu_res=1032 drives SRAM_ADDR=4 then 5.
- Back-to-back loads at 1028 then 1036 with upstream held while ready low: two distinct results, no duplicate access (exactly 4 half reads).
- Reset mid-write: rst low during HI of a write:
  - immediately WE_N=1, DQ high-Z, ready=1 while rst is low;
  - after release, a load at 1024 completes normally.
- With MEM_STAGE_READ_BUFFER_EN:
  - a repeat load at 1024 returns 0xDEADBEEF with ready=1 in the same cycle and no OE_N pulse;
  - a store of 0x0 to 1024 followed by a hit returns 0x0.

Source files
------------

// File: rtl/mem_stage_sram_pkg.sv
// mem_stage_sram_pkg: shared widths, FSM encoding and counter sizing for the SRAM memory stage.
`default_nettype none

package mem_stage_sram_pkg;

    localparam int WORD_LEN = 32;
    localparam int SRAM_DW  = 16;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LO   = 2'd1,
        ST_HI   = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    // A one-cycle half still needs a 1-bit counter to keep the port widths legal.
    function automatic int cnt_width(input int half_cycles);
        return (half_cycles > 1) ? $clog2(half_cycles) : 1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/mem_stage_sram_sram_ctrl.sv
// sram_ctrl: sequences one 32-bit access as two half-word accesses on a 16-bit async SRAM.
`default_nettype none

module sram_ctrl
    import mem_stage_sram_pkg::*;
#(
    parameter int HALF_CYCLES = 2,
    parameter int SRAM_AW     = 18
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                i_req,
    input  logic                i_write,
    input  logic [SRAM_AW-2:0]  i_word,
    input  logic [WORD_LEN-1:0] i_wdata,
    output logic                o_ready,
    output logic                o_idle,
    output logic                o_done,
    output logic                o_write,
    output logic [SRAM_AW-2:0]  o_word,
    output logic [WORD_LEN-1:0] o_wdata,
    output logic [WORD_LEN-1:0] o_rdata,
    inout  wire  [SRAM_DW-1:0]  SRAM_DQ,
    output logic [SRAM_AW-1:0]  SRAM_ADDR,
    output logic                SRAM_WE_N,
    output logic                SRAM_OE_N
);

    localparam int            CW         = cnt_width(HALF_CYCLES);
    localparam logic [CW-1:0] C_CNT_LAST = CW'(HALF_CYCLES - 1);

    state_t                r_state;
    state_t                w_state_nxt;
    logic [CW-1:0]         r_cnt;
    logic [CW-1:0]         w_cnt_nxt;
    logic                  r_write;
    logic [SRAM_AW-2:0]    r_word;
    logic [WORD_LEN-1:0]   r_wdata;
    logic [WORD_LEN-1:0]   r_rdata;
    logic [SRAM_DW-1:0]    r_rd_lo;
    logic                  w_req;
    logic                  w_last;
    logic                  w_half;
    logic                  w_dq_oe;
    logic [SRAM_DW-1:0]    w_dq_out;

    // Holding reset masks the request so the stage reports ready while frozen in reset.
    assign w_req    = i_req & rst;
    assign w_last   = (r_cnt == C_CNT_LAST);
    assign w_half   = (r_state == ST_HI);
    assign w_dq_out = w_half ? r_wdata[WORD_LEN-1:SRAM_DW] : r_wdata[SRAM_DW-1:0];
    assign SRAM_DQ  = w_dq_oe ? w_dq_out : {SRAM_DW{1'bz}};

    assign o_idle  = (r_state == ST_IDLE);
    assign o_done  = (r_state == ST_DONE);
    assign o_write = r_write;
    assign o_word  = r_word;
    assign o_wdata = r_wdata;
    assign o_rdata = r_rdata;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // The low half is staged separately so mem_data only changes once the whole load is in.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_write <= 1'b0;
            r_word  <= '0;
            r_wdata <= '0;
            r_rdata <= '0;
            r_rd_lo <= '0;
        end else begin
            if (r_state == ST_IDLE && w_req) begin
                r_write <= i_write;
                r_word  <= i_word;
                r_wdata <= i_wdata;
            end
            if (r_state == ST_LO && w_last && !r_write) begin
                r_rd_lo <= SRAM_DQ;
            end
            if (r_state == ST_HI && w_last && !r_write) begin
                r_rdata <= {SRAM_DQ, r_rd_lo};
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        o_ready     = 1'b0;
        SRAM_ADDR   = '0;
        SRAM_WE_N   = 1'b1;
        SRAM_OE_N   = 1'b1;
        w_dq_oe     = 1'b0;
        case (r_state)
            ST_IDLE: begin
                o_ready   = ~w_req;
                w_cnt_nxt = '0;
                if (w_req) begin
                    w_state_nxt = ST_LO;
                end
            end
            ST_LO, ST_HI: begin
                SRAM_ADDR = {r_word, w_half};
                if (r_write) begin
                    w_dq_oe   = 1'b1;
                    SRAM_WE_N = w_last;  // strobe drops for the final cycle, data held
                end else begin
                    SRAM_OE_N = 1'b0;
                end
                if (w_last) begin
                    w_cnt_nxt   = '0;
                    w_state_nxt = (r_state == ST_LO) ? ST_HI : ST_DONE;
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
            ST_DONE: begin
                o_ready     = 1'b1;
                w_state_nxt = ST_IDLE;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/mem_stage_sram.sv
// mem_stage_sram: pipeline memory stage over a 16-bit async SRAM with control pass-throughs.
// Optional one-entry read buffer enabled by `define MEM_STAGE_READ_BUFFER_EN.
`default_nettype none

module mem_stage_sram
    import mem_stage_sram_pkg::*;
#(
    parameter logic [31:0] ADDR_BASE   = 32'd1024,
    parameter int          HALF_CYCLES = 2,
    parameter int          SRAM_AW     = 18
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                wb_en_in,
    input  logic                mem_r_en,
    input  logic                mem_w_en,
    input  logic [WORD_LEN-1:0] alu_res,
    input  logic [WORD_LEN-1:0] val_rm,
    input  logic [3:0]          dest_in,
    output logic                ready,
    output logic                wb_en_out,
    output logic                mem_r_en_out,
    output logic [WORD_LEN-1:0] alu_res_out,
    output logic [3:0]          dest_out,
    output logic [WORD_LEN-1:0] mem_data,
    inout  wire  [SRAM_DW-1:0]  SRAM_DQ,
    output logic [SRAM_AW-1:0]  SRAM_ADDR,
    output logic                SRAM_WE_N,
    output logic                SRAM_OE_N
);

    logic [WORD_LEN-1:0] w_off;
    logic [SRAM_AW-2:0]  w_word;
    logic                w_req;
    logic                w_hit;
    logic                w_ctrl_idle;
    logic                w_ctrl_done;
    logic                w_ctrl_write;
    logic [SRAM_AW-2:0]  w_ctrl_word;
    logic [WORD_LEN-1:0] w_ctrl_wdata;
    logic [WORD_LEN-1:0] w_ctrl_rdata;

    assign wb_en_out    = wb_en_in;
    assign mem_r_en_out = mem_r_en;
    assign alu_res_out  = alu_res;
    assign dest_out     = dest_in;

    // Addresses below the base wrap silently within the SRAM word space.
    assign w_off  = alu_res - ADDR_BASE;
    assign w_word = w_off[SRAM_AW:2];
    assign w_req  = mem_r_en | mem_w_en;

    wire w_unused_off = ^{w_off[WORD_LEN-1:SRAM_AW+1], w_off[1:0]};

    sram_ctrl #(
        .HALF_CYCLES (HALF_CYCLES),
        .SRAM_AW     (SRAM_AW)
    ) u_sram_ctrl (
        .clk       (clk),
        .rst       (rst),
        .i_req     (w_req & ~w_hit),
        .i_write   (mem_w_en),
        .i_word    (w_word),
        .i_wdata   (val_rm),
        .o_ready   (ready),
        .o_idle    (w_ctrl_idle),
        .o_done    (w_ctrl_done),
        .o_write   (w_ctrl_write),
        .o_word    (w_ctrl_word),
        .o_wdata   (w_ctrl_wdata),
        .o_rdata   (w_ctrl_rdata),
        .SRAM_DQ   (SRAM_DQ),
        .SRAM_ADDR (SRAM_ADDR),
        .SRAM_WE_N (SRAM_WE_N),
        .SRAM_OE_N (SRAM_OE_N)
    );

`ifdef MEM_STAGE_READ_BUFFER_EN
    logic                r_buf_valid;
    logic [SRAM_AW-2:0]  r_buf_word;
    logic [WORD_LEN-1:0] r_buf_data;

    assign w_hit    = rst & w_ctrl_idle & mem_r_en & ~mem_w_en & r_buf_valid & (w_word == r_buf_word);
    assign mem_data = w_hit ? r_buf_data : w_ctrl_rdata;

    // Loads refill the entry; stores only refresh it when they land on the buffered word.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_buf_valid <= 1'b0;
            r_buf_word  <= '0;
            r_buf_data  <= '0;
        end else if (w_ctrl_done) begin
            if (!w_ctrl_write) begin
                r_buf_valid <= 1'b1;
                r_buf_word  <= w_ctrl_word;
                r_buf_data  <= w_ctrl_rdata;
            end else if (r_buf_valid && (w_ctrl_word == r_buf_word)) begin
                r_buf_data <= w_ctrl_wdata;
            end
        end
    end
`else
    assign w_hit    = 1'b0;
    assign mem_data = w_ctrl_rdata;

    wire w_unused_ctrl = ^{w_ctrl_idle, w_ctrl_done, w_ctrl_write, w_ctrl_word, w_ctrl_wdata};
`endif

endmodule

`default_nettype wire

// File: tb/tb_mem_stage_sram.sv
// tb_mem_stage_sram: table-driven directed checks of mem_stage_sram against a 16-bit SRAM model.
`default_nettype none

module tb_mem_stage_sram;

    localparam logic [1:0] OP_NOP = 2'd0;
    localparam logic [1:0] OP_ST  = 2'd1;
    localparam logic [1:0] OP_LD  = 2'd2;

    typedef struct {
        logic [1:0]  op;
        logic [31:0] alu;
        logic [31:0] rm;
        int          exp_busy;
        logic        chk_data;
        logic [31:0] exp_data;
        int          exp_act;
        logic [17:0] exp_addr0;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        wb_en_in, mem_r_en, mem_w_en;
    logic [31:0] alu_res, val_rm;
    logic [3:0]  dest_in;
    logic        ready, wb_en_out, mem_r_en_out;
    logic [31:0] alu_res_out, mem_data;
    logic [3:0]  dest_out;
    wire  [15:0] sram_dq;
    logic [17:0] sram_addr;
    logic        sram_we_n, sram_oe_n;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    mem_stage_sram #(
        .ADDR_BASE   (32'd1024),
        .HALF_CYCLES (2),
        .SRAM_AW     (18)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .wb_en_in     (wb_en_in),
        .mem_r_en     (mem_r_en),
        .mem_w_en     (mem_w_en),
        .alu_res      (alu_res),
        .val_rm       (val_rm),
        .dest_in      (dest_in),
        .ready        (ready),
        .wb_en_out    (wb_en_out),
        .mem_r_en_out (mem_r_en_out),
        .alu_res_out  (alu_res_out),
        .dest_out     (dest_out),
        .mem_data     (mem_data),
        .SRAM_DQ      (sram_dq),
        .SRAM_ADDR    (sram_addr),
        .SRAM_WE_N    (sram_we_n),
        .SRAM_OE_N    (sram_oe_n)
    );

    // SRAM model: low 8 address bits index a 256-entry array; writes sampled mid-cycle.
    logic [15:0] mem [0:255];
    logic        init_done = 1'b0;
    logic [17:0] addr_log [$];

    assign sram_dq = (!sram_oe_n) ? mem[sram_addr[7:0]] : 16'hzzzz;

    always @(negedge clk) begin
        if (!init_done) begin
            for (int i = 0; i < 256; i++) mem[i] = 16'hA000 + 16'(i);
            init_done = 1'b1;
        end else begin
            if (!sram_we_n) mem[sram_addr[7:0]] = sram_dq;
            if (!sram_we_n || !sram_oe_n) addr_log.push_back(sram_addr);
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    int          cap_busy;
    logic [31:0] cap_data, cap_aro;
    logic        cap_wb, cap_mr, cap_we, cap_oe;
    logic [3:0]  cap_dest;

    task automatic set_idle();
        wb_en_in = 1'b0; mem_r_en = 1'b0; mem_w_en = 1'b0;
        alu_res = 32'h0; val_rm = 32'h0; dest_in = 4'h0;
    endtask

    // Issue one instruction and hold it (frozen upstream) until ready is seen high.
    task automatic run_op(input logic [1:0] op, input logic [31:0] alu, input logic [31:0] rm,
                          input logic [3:0] dst);
        @(posedge clk); #1;
        wb_en_in = (op != OP_ST);
        mem_r_en = (op == OP_LD);
        mem_w_en = (op == OP_ST);
        alu_res  = alu;
        val_rm   = rm;
        dest_in  = dst;
        cap_busy = 0;
        @(negedge clk);
        while (!ready && cap_busy < 20) begin
            cap_busy++;
            @(negedge clk);
        end
        cap_data = mem_data;
        cap_aro  = alu_res_out;
        cap_wb   = wb_en_out;
        cap_mr   = mem_r_en_out;
        cap_dest = dest_out;
        cap_we   = sram_we_n;
        cap_oe   = sram_oe_n;
        @(posedge clk); #1;
        set_idle();
    endtask

    vec_t vecs [10];

    initial begin
        int start;
        vecs[0] = '{OP_NOP, 32'h0000_1234, 32'h0,           0, 1'b0, 32'h0,           0, 18'h0};
        vecs[1] = '{OP_ST,  32'd1024,      32'hDEAD_BEEF,   5, 1'b0, 32'h0,           2, 18'h0};
        vecs[2] = '{OP_LD,  32'd1024,      32'h0,           5, 1'b1, 32'hDEAD_BEEF,   4, 18'h0};
        vecs[3] = '{OP_ST,  32'd1028,      32'hCAFE_F00D,   5, 1'b0, 32'h0,           2, 18'h2};
        vecs[4] = '{OP_ST,  32'd1036,      32'h0123_4567,   5, 1'b0, 32'h0,           2, 18'h6};
        vecs[5] = '{OP_LD,  32'd1028,      32'h0,           5, 1'b1, 32'hCAFE_F00D,   4, 18'h2};
        vecs[6] = '{OP_LD,  32'd1036,      32'h0,           5, 1'b1, 32'h0123_4567,   4, 18'h6};
        vecs[7] = '{OP_LD,  32'd1032,      32'h0,           5, 1'b1, 32'hA005_A004,   4, 18'h4};
        vecs[8] = '{OP_LD,  32'd1020,      32'h0,           5, 1'b1, 32'hA0FF_A0FE,   4, 18'h3FFFE};
        vecs[9] = '{OP_NOP, 32'hFFFF_0000, 32'h0,           0, 1'b0, 32'h0,           0, 18'h0};

        set_idle();
        rst = 1'b0;
        #2;
        chk("reset_ready", 32'(ready), 32'h1);
        chk("reset_we_n", 32'(sram_we_n), 32'h1);
        chk("reset_oe_n", 32'(sram_oe_n), 32'h1);
        chk("reset_addr", 32'(sram_addr), 32'h0);
        chk("reset_mem_data", mem_data, 32'h0);
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;

        for (int i = 0; i < 10; i++) begin
            start = addr_log.size();
            run_op(vecs[i].op, vecs[i].alu, vecs[i].rm, 4'(i));
            chk($sformatf("v%0d_busy", i), 32'(cap_busy), 32'(vecs[i].exp_busy));
            if (vecs[i].chk_data) chk($sformatf("v%0d_data", i), cap_data, vecs[i].exp_data);
            chk($sformatf("v%0d_alu_out", i), cap_aro, vecs[i].alu);
            chk($sformatf("v%0d_dest_out", i), 32'(cap_dest), 32'(i));
            chk($sformatf("v%0d_wb_out", i), 32'(cap_wb), 32'(vecs[i].op != OP_ST));
            chk($sformatf("v%0d_mr_out", i), 32'(cap_mr), 32'(vecs[i].op == OP_LD));
            chk($sformatf("v%0d_pins_idle", i), {30'h0, cap_we, cap_oe}, 32'h3);
            chk($sformatf("v%0d_act_cycles", i), 32'(addr_log.size() - start), 32'(vecs[i].exp_act));
            if (vecs[i].exp_act > 0 && addr_log.size() > start) begin
                chk($sformatf("v%0d_addr_lo", i), 32'(addr_log[start]), 32'(vecs[i].exp_addr0));
                chk($sformatf("v%0d_addr_hi", i), 32'(addr_log[addr_log.size() - 1]),
                    32'(vecs[i].exp_addr0 + 18'd1));
            end
        end
        chk("sram_w0", 32'(mem[0]), 32'h0000_BEEF);
        chk("sram_w1", 32'(mem[1]), 32'h0000_DEAD);
        chk("sram_w2", 32'(mem[2]), 32'h0000_F00D);
        chk("sram_w7", 32'(mem[7]), 32'h0000_0123);

        // Reset asserted on the first HI cycle of a store: only the low half reaches SRAM.
        @(posedge clk); #1;
        mem_w_en = 1'b1; alu_res = 32'd1024; val_rm = 32'h1234_5678;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        #1;
        chk("midrst_we_n", 32'(sram_we_n), 32'h1);
        chk("midrst_oe_n", 32'(sram_oe_n), 32'h1);
        chk("midrst_ready", 32'(ready), 32'h1);
        chk("midrst_addr", 32'(sram_addr), 32'h0);
        chk("midrst_mem_data", mem_data, 32'h0);
        @(negedge clk);
        chk("midrst_ready_held", 32'(ready), 32'h1);
        @(posedge clk); #1;
        set_idle();
        rst = 1'b1;
        run_op(OP_LD, 32'd1024, 32'h0, 4'h3);
        chk("postrst_busy", 32'(cap_busy), 32'd5);
        chk("postrst_data", cap_data, 32'hDEAD_5678);

`ifdef MEM_STAGE_READ_BUFFER_EN
        run_op(OP_ST, 32'd1024, 32'hDEAD_BEEF, 4'h1);
        chk("buf_st_busy", 32'(cap_busy), 32'd5);
        run_op(OP_LD, 32'd1024, 32'h0, 4'h1);
        chk("buf_fill_busy", 32'(cap_busy), 32'd5);
        chk("buf_fill_data", cap_data, 32'hDEAD_BEEF);
        start = addr_log.size();
        run_op(OP_LD, 32'd1024, 32'h0, 4'h1);
        chk("buf_hit_busy", 32'(cap_busy), 32'd0);
        chk("buf_hit_data", cap_data, 32'hDEAD_BEEF);
        chk("buf_hit_no_sram", 32'(addr_log.size() - start), 32'd0);
        run_op(OP_ST, 32'd1024, 32'h0, 4'h1);
        chk("buf_st0_busy", 32'(cap_busy), 32'd5);
        start = addr_log.size();
        run_op(OP_LD, 32'd1024, 32'h0, 4'h1);
        chk("buf_hit2_busy", 32'(cap_busy), 32'd0);
        chk("buf_hit2_data", cap_data, 32'h0);
        chk("buf_hit2_no_sram", 32'(addr_log.size() - start), 32'd0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
